mul_seq_ctrl: RTL

- Sequencer for the Nios II custom/extension multiply path.
- Computes the full 64-bit product of two 32-bit operands on one shared, pipelined 16x16 unsigned multiplier. The block issues four partial products, accumulates them, applies a signed correction and returns the requested 32-bit word.
- Selects mul, mulxuu, mulxsu or mulxss semantics.
- Sits between the instruction/accelerator front end (valid/ready request) and the writeback path (valid/ready response).

---
 rtl/mul_seq_ctrl_if.sv | 36 +++
 rtl/mul_seq_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle for the sequential multiply controller.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. Once valid is raised, the
// producer holds valid and its payload stable until that edge. Ready may
// change freely, and the producer must not wait for ready before raising
// valid.
//
// Signals
//   req_valid   : request present (front end -> sequencer)
//   req_ready   : sequencer can take a request
//   req_src1/2  : 32-bit operands A and B
//   req_op      : 00 mul, 01 mulxuu, 10 mulxsu, 11 mulxss
//   resp_valid  : result present (sequencer -> writeback)
//   resp_ready  : writeback takes the result
//   resp_result : selected 32-bit result word
interface mul_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [1:0]  req_op;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;

  modport master (
    output req_valid, req_src1, req_src2, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_src1, req_src2, req_op, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32 multiply sequencer built around one pipelined 16x16
// unsigned multiplier. It issues four partial products, accumulates them
// into a 64-bit sum, applies the signed correction to the high word and
// returns the word selected by the op (mul, mulxuu, mulxsu, mulxss).
//
// Ports
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   flush     : synchronous abort of any operation in flight
//   bus       : request/response channels (slave side)
//   busy      : high whenever the FSM is not in IDLE
//   dbg_state : current FSM state encoding
//               (0 IDLE, 1 ISSUE, 2 DRAIN, 3 CORR, 4 RESP)
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  mul_seq_ctrl_if.slave  bus,
  output logic           busy,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_CORR  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [63:0] acc_q;
  logic [1:0]  k_q;
  logic [2:0]  cnt_q;
  logic [31:0] res_q;

  // Multiplier pipeline with a valid bit and a shift tag per stage.
  // Tag encoding: 0 -> shift 0, 1 -> shift 16, 2 -> shift 32.
  logic [31:0]            pipe_q [MUL_LATENCY];
  logic [1:0]             tag_q  [MUL_LATENCY];
  logic [MUL_LATENCY-1:0] vld_q;

  logic        accept, issue, acc_en;
  logic [15:0] mul_a, mul_b;
  logic [1:0]  issue_tag;
  logic [31:0] prod_out;
  logic [63:0] addend;
  logic [31:0] corr, hi_corr;

  assign accept = (state_q == S_IDLE) && bus.req_valid && !flush;
  assign issue  = (state_q == S_ISSUE);

  // k[0] picks the high half of A, k[1] the high half of B.
  assign mul_a     = k_q[0] ? a_q[31:16] : a_q[15:0];
  assign mul_b     = k_q[1] ? b_q[31:16] : b_q[15:0];
  assign issue_tag = (k_q == 2'd3) ? 2'd2 : ((k_q == 2'd0) ? 2'd0 : 2'd1);

  assign acc_en   = vld_q[MUL_LATENCY-1];
  assign prod_out = pipe_q[MUL_LATENCY-1];

  always_comb begin
    addend = 64'd0;
    case (tag_q[MUL_LATENCY-1])
      2'd0:    addend = {32'd0, prod_out};
      2'd1:    addend = {16'd0, prod_out, 16'd0};
      default: addend = {prod_out, 32'd0};
    endcase
  end

  // Unsigned product minus the two's-complement weight of each sign bit.
  assign corr    = ((op_q[1] && a_q[31]) ? b_q : 32'd0)
                 + (((op_q == 2'b11) && b_q[31]) ? a_q : 32'd0);
  assign hi_corr = acc_q[63:32] - corr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (k_q == 2'd3) state_d = S_DRAIN;
      // Leave as soon as the fourth product is being added on this edge,
      // so CORR always sees the complete sum.
      S_DRAIN: if ((cnt_q == 3'd4) || (acc_en && (cnt_q == 3'd3)))
                 state_d = S_CORR;
      S_CORR:  state_d = S_RESP;
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pipe_q[i] <= 32'd0;
        tag_q[i]  <= 2'd0;
      end
      vld_q <= '0;
    end else begin
      pipe_q[0] <= {16'd0, mul_a} * {16'd0, mul_b};
      tag_q[0]  <= issue_tag;
      vld_q[0]  <= issue && !flush;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        vld_q[i]  <= vld_q[i-1] && !flush;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      acc_q   <= 64'd0;
      k_q     <= 2'd0;
      cnt_q   <= 3'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        acc_q <= 64'd0;
        cnt_q <= 3'd0;
        k_q   <= 2'd0;
        res_q <= 32'd0;
      end else if (accept) begin
        a_q   <= bus.req_src1;
        b_q   <= bus.req_src2;
        op_q  <= bus.req_op;
        acc_q <= 64'd0;
        k_q   <= 2'd0;
        cnt_q <= 3'd0;
      end else begin
        if (acc_en) begin
          acc_q <= acc_q + addend;
          cnt_q <= cnt_q + 3'd1;
        end
        if (issue) k_q <= k_q + 2'd1;
        if (state_q == S_CORR)
          res_q <= (op_q == 2'b00) ? acc_q[31:0] : hi_corr;
      end
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.resp_valid  = (state_q == S_RESP);
  assign bus.resp_result = res_q;
  assign busy            = (state_q != S_IDLE);
  assign dbg_state       = state_q;

endmodule
